// File: rtl/cpu_pkg.sv
// Shared register-file types for the issue scoreboard: register index,
// architectural constants and the write-set descriptor used by issue and writeback.
package cpu_pkg;

   localparam int NREG = 8;

   typedef logic [$clog2(NREG)-1:0] reg_idx_t;

   localparam reg_idx_t OVF_REG = reg_idx_t'(7);

   typedef struct packed {
      reg_idx_t dest;
      logic     wr;
      logic     ovf;
   } wr_set_t;

   // One-hot-or mask of registers touched by a write set; dest == OVF_REG collapses to one bit.
   function automatic logic [NREG-1:0] set_mask(input wr_set_t ws);
      logic [NREG-1:0] m;
      m = '0;
      if (ws.wr)  m[ws.dest] = 1'b1;
      if (ws.ovf) m[OVF_REG] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/sb_counter.sv
// One per-register pending-write counter: up on issue, down on retire, cleared by flush.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic dec_i,
   input  logic clr_i,
   output logic nz_o,
   output logic one_o,
   output logic full_o,
   output logic underflow_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign nz_o        = |cnt_q;
   assign one_o       = (cnt_q == CNT_W'(1));
   assign full_o      = &cnt_q;
   // Simultaneous inc/dec nets to zero change, so it can never underflow.
   assign underflow_o = dec_i & ~inc_i & ~clr_i & ~nz_o;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && !dec_i && !full_o)
         cnt_d = cnt_q + CNT_W'(1);
      else if (dec_i && !inc_i && nz_o)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-stage scoreboard: tracks in-flight register writes, holds issue on RAW
// hazards or counter saturation, counts stall cycles and flags retire underflow.
module regfile_scoreboard
   import cpu_pkg::*;
#(
   parameter int CNT_W     = 2,
   parameter bit WB_BYPASS = 1'b1,
   parameter int PERF_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              iss_valid_i,
   input  logic [2:0]        iss_src1_i,
   input  logic [2:0]        iss_src2_i,
   input  logic              iss_use1_i,
   input  logic              iss_use2_i,
   input  logic [2:0]        iss_dest_i,
   input  logic              iss_wr_i,
   input  logic              iss_ovf_i,
   input  logic [2:0]        wb_dest_i,
   input  logic              wb_wr_i,
   input  logic              wb_ovf_i,
   output logic              iss_ready_o,
   output logic              stall_o,
   output logic [NREG-1:0]   pending_o,
   output logic [PERF_W-1:0] stall_cnt_o,
   output logic              err_o
);

   // Handshake: an instruction issues on a cycle where iss_valid_i && iss_ready_o;
   // iss_ready_o is combinational and never depends on iss_valid_i.
   wr_set_t         iss_ws, wb_ws;
   logic [NREG-1:0] iss_set, ret_set;
   logic [NREG-1:0] nz, one, full, unf, inc, dec;
   logic            busy1, busy2, raw, struct_blk, fire;
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   logic            err_q, err_d;

   assign iss_ws  = '{dest: iss_src_dest(iss_dest_i), wr: iss_wr_i, ovf: iss_ovf_i};
   assign wb_ws   = '{dest: iss_src_dest(wb_dest_i), wr: wb_wr_i, ovf: wb_wr_i & wb_ovf_i};
   assign iss_set = set_mask(iss_ws);
   assign ret_set = set_mask(wb_ws);

   function automatic reg_idx_t iss_src_dest(input logic [2:0] v);
      return reg_idx_t'(v);
   endfunction

   // The register file writes on negedge, so a last in-flight write retiring now is readable.
   always_comb begin
      busy1 = nz[iss_src1_i];
      busy2 = nz[iss_src2_i];
      if (WB_BYPASS) begin
         if (ret_set[iss_src1_i] && one[iss_src1_i]) busy1 = 1'b0;
         if (ret_set[iss_src2_i] && one[iss_src2_i]) busy2 = 1'b0;
      end
   end

   assign raw         = (iss_use1_i & busy1) | (iss_use2_i & busy2);
   assign struct_blk  = |(iss_set & full & ~ret_set);
   assign iss_ready_o = ~flush_i & ~raw & ~struct_blk;
   assign stall_o     = iss_valid_i & ~iss_ready_o;
   assign fire        = iss_valid_i & iss_ready_o;
   assign inc         = fire ? iss_set : '0;
   assign dec         = flush_i ? '0 : ret_set;

   for (genvar r = 0; r < NREG; r++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk         (clk),
         .rst_n       (rst_n),
         .inc_i       (inc[r]),
         .dec_i       (dec[r]),
         .clr_i       (flush_i),
         .nz_o        (nz[r]),
         .one_o       (one[r]),
         .full_o      (full[r]),
         .underflow_o (unf[r])
      );
   end

   assign pending_o = nz;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
      err_d = err_q | (|unf);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign err_o       = err_q;

endmodule
